// File: rtl/led_blink_pkg.sv
// Mode encodings shared by the blink controller and its channels.
// No logic; constants only.
package led_blink_pkg;
    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
    localparam logic [MODE_W-1:0] MODE_BURST = 2'd3;
endpackage

// File: rtl/led_blink_ch.sv
// One LED channel: period counter, burst counter, mode register, registered led/tick.
// Latency: led/tick lag the counter by one cycle; a load takes effect at its own edge.
module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int CNT_W    = 32,
    parameter int BURST_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MODE_W-1:0]  ld_mode,
    input  logic [CNT_W-1:0]   ld_period,
    input  logic [CNT_W-1:0]   ld_high,
    input  logic [BURST_W-1:0] ld_count,
    output logic               led,
    output logic               tick
);

    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(CLK_FREQ);
    localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(CLK_FREQ / 2);

    logic [MODE_W-1:0]  mode;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   high;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] rem;
    logic               wrap;

    assign wrap = (cnt == period - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= MODE_BLINK;
            period <= RST_PERIOD;
            high   <= RST_HIGH;
            cnt    <= '0;
            rem    <= '0;
            led    <= 1'b0;
            tick   <= 1'b0;
        end else if (load) begin
            // An empty burst is simply an idle channel.
            mode   <= (ld_mode == MODE_BURST && ld_count == '0) ? MODE_OFF : ld_mode;
            period <= (ld_period == '0) ? CNT_W'(1) : ld_period;
            high   <= ld_high;
            rem    <= ld_count;
            cnt    <= '0;
            led    <= 1'b0;
            tick   <= 1'b0;
        end else begin
            case (mode)
                MODE_OFF: begin
                    cnt  <= '0;
                    led  <= 1'b0;
                    tick <= 1'b0;
                end
                MODE_ON: begin
                    cnt  <= '0;
                    led  <= 1'b1;
                    tick <= 1'b0;
                end
                default: begin
                    cnt  <= wrap ? '0 : cnt + CNT_W'(1);
                    led  <= (cnt < high);
                    tick <= wrap;
                    // Last burst wrap still ticks; the led drops one edge later.
                    if (mode == MODE_BURST && wrap) begin
                        rem <= rem - BURST_W'(1);
                        if (rem == BURST_W'(1)) begin
                            mode <= MODE_OFF;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink/tick generator with a valid/ready config port and channel decode.
// Latency: config applies at the transfer edge; backpressure: cfg_ready drops for one cycle after each transfer.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter  int CLK_FREQ = 27_000_000,
    parameter  int NUM_CH   = 2,
    parameter  int CNT_W    = 32,
    parameter  int BURST_W  = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [MODE_W-1:0]  cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [BURST_W-1:0] cfg_count,
    output logic               cfg_err,
    output logic [NUM_CH-1:0]  led,
    output logic [NUM_CH-1:0]  tick
);

    logic              xfer;
    logic [NUM_CH-1:0] ch_hit;

    assign xfer = cfg_valid && cfg_ready;

    // A channel index that hits no channel is reported as an error.
    always_comb begin
        ch_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit[i] = (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= !xfer;
            cfg_err   <= xfer && !(|ch_hit);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_blink_ch #(
            .CLK_FREQ (CLK_FREQ),
            .CNT_W    (CNT_W),
            .BURST_W  (BURST_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (xfer && ch_hit[g]),
            .ld_mode   (cfg_mode),
            .ld_period (cfg_period),
            .ld_high   (cfg_high),
            .ld_count  (cfg_count),
            .led       (led[g]),
            .tick      (tick[g])
        );
    end

endmodule
